// File: rtl/register_file_multiport_if.sv
// -----------------------------------------------------------------------------
// register_file_multiport_if
//   Bus between the pipeline (decode + writeback) and the integer register file.
//   Groups the read ports, the write port and the scoreboard reserve port.
//
//   Parameters: XLEN (data width), AW (register address width), NRP (read ports)
//
//   Signals (direction seen from the register file, i.e. the slave modport):
//     rs                    in   NRP*AW    read addresses, port i = rs[i*AW +: AW]
//     read_data             out  NRP*XLEN  read data, port i = read_data[i*XLEN +: XLEN]
//     read_busy             out  NRP       port i's register has an outstanding producer
//     register_write        in   AW        write address
//     write_data            in   XLEN      write data
//     register_write_enable in   1         commit write_data at next rising edge
//     reserve_enable        in   1         mark reserve_reg busy
//     reserve_reg           in   AW        destination register being reserved
// -----------------------------------------------------------------------------
interface register_file_multiport_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5,
   parameter int NRP  = 2
);
   logic [NRP*AW-1:0]   rs;
   logic [NRP*XLEN-1:0] read_data;
   logic [NRP-1:0]      read_busy;
   logic [AW-1:0]       register_write;
   logic [XLEN-1:0]     write_data;
   logic                register_write_enable;
   logic                reserve_enable;
   logic [AW-1:0]       reserve_reg;

   // Pipeline side: drives addresses, write and reserve requests.
   modport master (
      output rs, register_write, write_data, register_write_enable,
             reserve_enable, reserve_reg,
      input  read_data, read_busy
   );

   // Register file side.
   modport slave (
      input  rs, register_write, write_data, register_write_enable,
             reserve_enable, reserve_reg,
      output read_data, read_busy
   );
endinterface

// File: rtl/register_file_multiport.sv
// -----------------------------------------------------------------------------
// register_file_multiport
//   Parametrised RV32I integer register file: NUM_READ_PORTS combinational
//   read ports, one synchronous write port, optional write-to-read bypass,
//   optional hardwired-zero x0 and a per-register busy scoreboard used by
//   decode to detect RAW hazards against in-flight producers.
//
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  synchronous, active-high; clears all registers and busy bits
//     bus    register_file_multiport_if.slave (read/write/reserve bus)
// -----------------------------------------------------------------------------
module register_file_multiport #(
   parameter int XLEN           = 32,
   parameter int NUM_REGS       = 32,
   parameter int NUM_READ_PORTS = 2,
   parameter int WRITE_BYPASS   = 1,
   parameter int ZERO_REG       = 1
) (
   input logic                        clk,
   input logic                        reset,
   register_file_multiport_if.slave   bus
);
   localparam int AW = $clog2(NUM_REGS);

   logic [XLEN-1:0]     w_regs [NUM_REGS];
   logic [NUM_REGS-1:0] w_busy;
   logic                w_wr_ok;
   logic                w_rsv_ok;

   // Writes and reserves targeting a hardwired x0 are dropped here, so the
   // per-register logic below never has to special-case register 0.
   // Logical && keeps an X address harmless while its enable is low.
   assign w_wr_ok  = bus.register_write_enable &&
                     !((ZERO_REG != 0) && (bus.register_write == '0));
   assign w_rsv_ok = bus.reserve_enable &&
                     !((ZERO_REG != 0) && (bus.reserve_reg == '0));

   // ---------------------------------------------------------------------
   // Storage and scoreboard, one slice per architectural register
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [XLEN-1:0] r_data;
         logic            r_busy;
         logic            w_wr_hit;
         logic            w_rsv_hit;

         assign w_wr_hit  = w_wr_ok  && (bus.register_write == AW'(gi));
         assign w_rsv_hit = w_rsv_ok && (bus.reserve_reg    == AW'(gi));

         always_ff @(posedge clk) begin
            if (reset) begin
               r_data <= '0;
               r_busy <= 1'b0;
            end else begin
               if (w_wr_hit) begin
                  r_data <= bus.write_data;
               end
               // A reserve in the same cycle as the releasing write belongs
               // to a newer producer, so it takes priority over the clear.
               if (w_rsv_hit) begin
                  r_busy <= 1'b1;
               end else if (w_wr_hit) begin
                  r_busy <= 1'b0;
               end
            end
         end

         assign w_regs[gi] = r_data;
         assign w_busy[gi] = r_busy;
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Read ports: fully independent, zero latency
   // ---------------------------------------------------------------------
   generate
      for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_rd
         logic [AW-1:0] w_rs;
         logic          w_byp;
         logic          w_zero;

         assign w_rs   = bus.rs[gi*AW +: AW];
         assign w_byp  = (WRITE_BYPASS != 0) && bus.register_write_enable &&
                         (bus.register_write == w_rs);
         assign w_zero = (ZERO_REG != 0) && (w_rs == '0);

         assign bus.read_data[gi*XLEN +: XLEN] =
            w_zero ? '0 :
            w_byp  ? bus.write_data :
                     w_regs[w_rs];

         // A forwarded releasing write already supplies the value, so the
         // consumer must not stall on it. busy[0] is never set under a
         // hardwired x0, so no extra zero check is needed.
         assign bus.read_busy[gi] = w_busy[w_rs] && !w_byp;
      end
   endgenerate
endmodule

// File: tb/tb_register_file_multiport.sv
module tb_register_file_multiport;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // a: default config; b: no bypass; c: ordinary x0; d: 3 ports, 64-bit
   register_file_multiport_if #(.XLEN(32), .AW(5), .NRP(2)) ia ();
   register_file_multiport_if #(.XLEN(32), .AW(5), .NRP(2)) ib ();
   register_file_multiport_if #(.XLEN(32), .AW(5), .NRP(2)) ic ();
   register_file_multiport_if #(.XLEN(64), .AW(5), .NRP(3)) id ();

   register_file_multiport #(.XLEN(32), .NUM_REGS(32), .NUM_READ_PORTS(2),
      .WRITE_BYPASS(1), .ZERO_REG(1)) dut_a (.clk(clk), .reset(reset), .bus(ia));
   register_file_multiport #(.XLEN(32), .NUM_REGS(32), .NUM_READ_PORTS(2),
      .WRITE_BYPASS(0), .ZERO_REG(1)) dut_b (.clk(clk), .reset(reset), .bus(ib));
   register_file_multiport #(.XLEN(32), .NUM_REGS(32), .NUM_READ_PORTS(2),
      .WRITE_BYPASS(1), .ZERO_REG(0)) dut_c (.clk(clk), .reset(reset), .bus(ic));
   register_file_multiport #(.XLEN(64), .NUM_REGS(32), .NUM_READ_PORTS(3),
      .WRITE_BYPASS(1), .ZERO_REG(1)) dut_d (.clk(clk), .reset(reset), .bus(id));

   task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      checks++;
      assert (obs === exp)
         $display("check %-16s obs=%0h exp=%0h ok", tag, obs, exp);
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_all();
      ia.register_write_enable = 1'b0; ia.reserve_enable = 1'b0;
      ib.register_write_enable = 1'b0; ib.reserve_enable = 1'b0;
      ic.register_write_enable = 1'b0; ic.reserve_enable = 1'b0;
      id.register_write_enable = 1'b0; id.reserve_enable = 1'b0;
   endtask

   initial begin
      ia.rs = '0; ia.register_write = '0; ia.write_data = '0; ia.reserve_reg = '0;
      ib.rs = '0; ib.register_write = '0; ib.write_data = '0; ib.reserve_reg = '0;
      ic.rs = '0; ic.register_write = '0; ic.write_data = '0; ic.reserve_reg = '0;
      id.rs = '0; id.register_write = '0; id.write_data = '0; id.reserve_reg = '0;
      idle_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // 1: everything reads zero / not busy after reset
      for (int r = 0; r < 32; r++) begin
         ia.rs = {5'(r), 5'(r)};
         id.rs = {5'(r), 5'(r), 5'(r)};
         #1;
         check($sformatf("rst_a_r%0d", r), {ia.read_busy, ia.read_data}, '0);
         check($sformatf("rst_d_r%0d", r), {id.read_busy, id.read_data}, '0);
      end

      // 2: write r5 with and without bypass
      @(negedge clk);
      ia.rs = {5'd0, 5'd5}; ib.rs = {5'd0, 5'd5};
      ia.register_write = 5'd5; ia.write_data = 32'hDEADBEEF; ia.register_write_enable = 1'b1;
      ib.register_write = 5'd5; ib.write_data = 32'hDEADBEEF; ib.register_write_enable = 1'b1;
      #1;
      check("byp_same_a", ia.read_data[31:0], 192'hDEADBEEF);
      check("nobyp_same_b", ib.read_data[31:0], 192'h0);
      @(negedge clk);
      idle_all();
      #1;
      check("byp_after_a", ia.read_data[31:0], 192'hDEADBEEF);
      check("nobyp_after_b", ib.read_data[31:0], 192'hDEADBEEF);

      // 3: write + reserve r0, hardwired vs ordinary x0
      @(negedge clk);
      ia.rs = '0; ic.rs = '0;
      ia.register_write = 5'd0; ia.write_data = 32'h1234; ia.register_write_enable = 1'b1;
      ia.reserve_reg = 5'd0; ia.reserve_enable = 1'b1;
      ic.register_write = 5'd0; ic.write_data = 32'h1234; ic.register_write_enable = 1'b1;
      ic.reserve_reg = 5'd0; ic.reserve_enable = 1'b1;
      #1;
      check("x0_same_a", {ia.read_busy, ia.read_data}, '0);
      check("x0_same_c", ic.read_data[31:0], 192'h1234);
      @(negedge clk);
      idle_all();
      #1;
      check("x0_after_a", {ia.read_busy, ia.read_data}, '0);
      check("x0_after_c", ic.read_data[31:0], 192'h1234);
      check("x0_busy_c", ic.read_busy[0], 192'h1);

      // 4: reserve r7, observe busy, release with bypassed write
      @(negedge clk);
      ia.rs = {5'd7, 5'd0};
      ia.reserve_reg = 5'd7; ia.reserve_enable = 1'b1;
      #1;
      check("rsv_same_cyc", ia.read_busy[1], 192'h0);
      @(negedge clk);
      idle_all();
      #1;
      check("rsv_busy", ia.read_busy[1], 192'h1);
      @(negedge clk);
      ia.register_write = 5'd7; ia.write_data = 32'h55; ia.register_write_enable = 1'b1;
      #1;
      check("rel_busy_same", ia.read_busy[1], 192'h0);
      check("rel_data_same", ia.read_data[63:32], 192'h55);
      @(negedge clk);
      idle_all();
      #1;
      check("rel_busy_after", ia.read_busy[1], 192'h0);
      check("rel_data_after", ia.read_data[63:32], 192'h55);

      // 5: reserve and write same register -> busy wins; different regs -> both apply
      @(negedge clk);
      ia.rs = {5'd10, 5'd9};
      ia.register_write = 5'd9; ia.write_data = 32'hA; ia.register_write_enable = 1'b1;
      ia.reserve_reg = 5'd9; ia.reserve_enable = 1'b1;
      @(negedge clk);
      idle_all();
      #1;
      check("same_rw_data", ia.read_data[31:0], 192'hA);
      check("same_rw_busy", ia.read_busy, 192'h1);
      @(negedge clk);
      ia.register_write = 5'd9; ia.write_data = 32'hB; ia.register_write_enable = 1'b1;
      ia.reserve_reg = 5'd10; ia.reserve_enable = 1'b1;
      @(negedge clk);
      idle_all();
      #1;
      check("diff_rw_data", ia.read_data[31:0], 192'hB);
      check("diff_rw_busy", ia.read_busy, 192'h2);

      // no-bypass config: busy is held while the releasing write is in flight
      @(negedge clk);
      ib.rs = {5'd0, 5'd3};
      ib.reserve_reg = 5'd3; ib.reserve_enable = 1'b1;
      @(negedge clk);
      idle_all();
      ib.register_write = 5'd3; ib.write_data = 32'h77; ib.register_write_enable = 1'b1;
      #1;
      check("nobyp_busy_wr", ib.read_busy[0], 192'h1);
      check("nobyp_data_wr", ib.read_data[31:0], 192'h0);
      @(negedge clk);
      idle_all();
      #1;
      check("nobyp_busy_aft", ib.read_busy[0], 192'h0);
      check("nobyp_data_aft", ib.read_data[31:0], 192'h77);

      // X on unused inputs while enables are low must not disturb state
      @(negedge clk);
      ia.register_write = 'x; ia.write_data = 'x; ia.reserve_reg = 'x;
      ia.rs = {5'd10, 5'd5};
      @(negedge clk);
      #1;
      check("x_in_data", ia.read_data, 192'h00000000_DEADBEEF);
      check("x_in_busy", ia.read_busy, 192'h2);
      ia.register_write = '0; ia.write_data = '0; ia.reserve_reg = '0;

      // 6: 3-port 64-bit config, all ports on r12
      @(negedge clk);
      id.rs = {5'd12, 5'd12, 5'd12};
      id.register_write = 5'd12; id.write_data = 64'h0123456789ABCDEF; id.register_write_enable = 1'b1;
      @(negedge clk);
      idle_all();
      #1;
      check("wide_3port", id.read_data, {3{64'h0123456789ABCDEF}});

      // mid-sequence reset with write and reserve active: both dropped
      @(negedge clk);
      reset = 1'b1;
      id.register_write = 5'd13; id.write_data = 64'hFFFF_FFFF_FFFF_FFFF; id.register_write_enable = 1'b1;
      id.reserve_reg = 5'd14; id.reserve_enable = 1'b1;
      ia.register_write = 5'd6; ia.write_data = 32'h99; ia.register_write_enable = 1'b1;
      ia.reserve_reg = 5'd6; ia.reserve_enable = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      idle_all();
      id.rs = {5'd14, 5'd13, 5'd12};
      ia.rs = {5'd6, 5'd5};
      #1;
      check("mid_rst_d", {id.read_busy, id.read_data}, '0);
      check("mid_rst_a", {ia.read_busy, ia.read_data}, '0);
      ia.rs = {5'd10, 5'd9};
      #1;
      check("mid_rst_a_busy", {ia.read_busy, ia.read_data}, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
